// File: rtl/jtag_uart_pkg.sv
// Shared state encoding, Avalon register map and FIFO constants for the JTAG UART TX arbiter.
package jtag_uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_CTRL = 3'd1,
      WAIT    = 3'd2,
      ARB     = 3'd3,
      WR_DATA = 3'd4
   } state_e;

   localparam logic       ADDR_DATA  = 1'b0;
   localparam logic       ADDR_CTRL  = 1'b1;
   localparam int         WSPACE_MSB = 31;
   localparam int         WSPACE_LSB = 16;
   localparam int         FIFO_DEPTH = 64;
   localparam logic [7:0] NEWLINE    = 8'h0A;

   // Index base+off reduced modulo n; base < n and off < n, so one subtraction suffices.
   function automatic logic [2:0] wrapIdx(input logic [2:0] base, input int unsigned off,
                                          input int unsigned n);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= n) sum = sum - n;
      return sum[2:0];
   endfunction

endpackage

// File: rtl/jtag_uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after the pointer, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [2:0]         ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [2:0]         idx_o,
   output logic               any_o
);
   import jtag_uart_pkg::*;

   logic [7:0] valid8;
   logic [7:0] grant8;
   logic [2:0] cand;
   logic       found;

   // Padding to 8 bits keeps the 3-bit candidate index legal for any NUM_REQ.
   always_comb begin
      valid8              = 8'h00;
      valid8[NUM_REQ-1:0] = valid_i;
      grant8              = 8'h00;
      idx_o               = 3'd0;
      cand                = 3'd0;
      found               = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrapIdx(ptr_i, k, NUM_REQ);
         if (!found && valid8[cand]) begin
            found        = 1'b1;
            idx_o        = cand;
            grant8[cand] = 1'b1;
         end
      end
      any_o   = found;
      grant_o = grant8[NUM_REQ-1:0];
   end

endmodule

// File: rtl/jtag_uart_tx_arbiter.sv
// Avalon-MM master sharing the JTAG UART TX FIFO among NUM_REQ byte streams with WSPACE credit.
// Define JTAG_TX_ARB_PKT_LOCK_EN to hold a grant on one requester until it writes a newline.
module jtag_uart_tx_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int POLL_GAP = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 av_address,
   output logic                 av_chipselect,
   output logic                 av_read_n,
   output logic                 av_write_n,
   output logic [31:0]          av_writedata,
   input  logic [31:0]          av_readdata,
   input  logic                 av_waitrequest,
   output logic                 busy,
   output logic [2:0]           grant_id
);
   import jtag_uart_pkg::*;

   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   state_e             state_q, state_d;
   logic [6:0]         credit_q, credit_d;
   logic [2:0]         rrPtr_q, rrPtr_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [7:0]         byte_q, byte_d;
   logic [2:0]         grantId_q, grantId_d;

   logic [NUM_REQ-1:0] arbValid;
   logic [NUM_REQ-1:0] arbGrant;
   logic [2:0]         arbIdx;
   logic               arbAny;
   logic [7:0]         selByte;
   logic [15:0]        wspace;
   logic [6:0]         wspaceCredit;
   logic               anyValid;
   logic               unusedReaddata;

`ifdef JTAG_TX_ARB_PKT_LOCK_EN
   logic               lock_q, lock_d;
   logic [2:0]         lockIdx_q, lockIdx_d;

   // While locked only the owning requester may win arbitration.
   always_comb begin
      arbValid = req_valid;
      for (int k = 0; k < NUM_REQ; k++) begin
         arbValid[k] = req_valid[k] && (!lock_q || (lockIdx_q == 3'(k)));
      end
   end
`else
   assign arbValid = req_valid;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid_i (arbValid),
      .ptr_i   (rrPtr_q),
      .grant_o (arbGrant),
      .idx_o   (arbIdx),
      .any_o   (arbAny)
   );

   always_comb begin
      selByte = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arbGrant[k]) selByte = req_data[8*k +: 8];
      end
   end

   assign anyValid       = |req_valid;
   assign wspace         = av_readdata[WSPACE_MSB:WSPACE_LSB];
   assign wspaceCredit   = (wspace >= 16'(FIFO_DEPTH)) ? 7'(FIFO_DEPTH) : wspace[6:0];
   assign unusedReaddata = ^av_readdata[WSPACE_LSB-1:0];

   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      rrPtr_d   = rrPtr_q;
      gap_d     = gap_q;
      byte_d    = byte_q;
      grantId_d = grantId_q;
`ifdef JTAG_TX_ARB_PKT_LOCK_EN
      lock_d    = lock_q;
      lockIdx_d = lockIdx_q;
`endif
      case (state_q)
         IDLE: begin
            if (anyValid) state_d = (credit_q != 7'd0) ? ARB : RD_CTRL;
         end
         RD_CTRL: begin
            if (!av_waitrequest) begin
               credit_d = wspaceCredit;
               gap_d    = '0;
               state_d  = (wspace == 16'd0) ? WAIT : ARB;
            end
         end
         WAIT: begin
            if (gap_q == GAP_W'(POLL_GAP - 1)) begin
               gap_d   = '0;
               state_d = RD_CTRL;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         ARB: begin
            if (arbAny) begin
               byte_d    = selByte;
               grantId_d = arbIdx;
               rrPtr_d   = (arbIdx == 3'(NUM_REQ - 1)) ? 3'd0 : arbIdx + 3'd1;
               state_d   = WR_DATA;
`ifdef JTAG_TX_ARB_PKT_LOCK_EN
               lock_d    = 1'b1;
               lockIdx_d = arbIdx;
            end else begin
               state_d = lock_q ? ARB : IDLE;
`else
            end else begin
               state_d = IDLE;
`endif
            end
         end
         WR_DATA: begin
            // Leave with credit already decremented so the exit choice sees the post-write value.
            if (!av_waitrequest) begin
               credit_d = (credit_q != 7'd0) ? credit_q - 7'd1 : 7'd0;
`ifdef JTAG_TX_ARB_PKT_LOCK_EN
               if (byte_q == NEWLINE) lock_d = 1'b0;
`endif
               if (!anyValid)              state_d = IDLE;
               else if (credit_d != 7'd0) state_d = ARB;
               else                        state_d = RD_CTRL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         credit_q  <= 7'd0;
         rrPtr_q   <= 3'd0;
         gap_q     <= '0;
         byte_q    <= 8'h00;
         grantId_q <= 3'd0;
`ifdef JTAG_TX_ARB_PKT_LOCK_EN
         lock_q    <= 1'b0;
         lockIdx_q <= 3'd0;
`endif
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         rrPtr_q   <= rrPtr_d;
         gap_q     <= gap_d;
         byte_q    <= byte_d;
         grantId_q <= grantId_d;
`ifdef JTAG_TX_ARB_PKT_LOCK_EN
         lock_q    <= lock_d;
         lockIdx_q <= lockIdx_d;
`endif
      end
   end

   // Bus outputs decode straight from registered state, so they hold until the slave releases.
   always_comb begin
      av_chipselect = 1'b0;
      av_read_n     = 1'b1;
      av_write_n    = 1'b1;
      av_address    = ADDR_DATA;
      av_writedata  = 32'h0;
      case (state_q)
         RD_CTRL: begin
            av_chipselect = 1'b1;
            av_read_n     = 1'b0;
            av_address    = ADDR_CTRL;
         end
         WR_DATA: begin
            av_chipselect = 1'b1;
            av_write_n    = 1'b0;
            av_writedata  = {24'h0, byte_q};
         end
         default: ;
      endcase
   end

   assign req_ready = (state_q == ARB) ? arbGrant : '0;
   assign busy      = (state_q != IDLE);
   assign grant_id  = grantId_q;

endmodule
